// File: rtl/confirm_input_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : confirm_input_ctrl_pkg
//  Description : Shared IO constants and the confirm-button FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package confirm_input_ctrl_pkg;

    // CPU IO load addresses decoded by the switch IO block
    localparam logic [31:0] IO_ADDR_CONFIRM = 32'hFFFF_FF00;
    localparam logic [31:0] IO_ADDR_SW0     = 32'hFFFF_FFF1;
    localparam logic [31:0] IO_ADDR_SW1     = 32'hFFFF_FFF3;
    localparam logic [31:0] IO_ADDR_SW2     = 32'hFFFF_FFF5;
    localparam logic [31:0] IO_ADDR_SW3     = 32'hFFFF_FFF7;
    localparam logic [31:0] IO_ADDR_SW4     = 32'hFFFF_FFF9;

    // Debounce FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DB_PRESS   = 3'd1,
        ST_PRESSED    = 3'd2,
        ST_HELD       = 3'd3,
        ST_DB_RELEASE = 3'd4
    } state_e;

endpackage : confirm_input_ctrl_pkg
`default_nettype wire

// File: rtl/confirm_input_ctrl_sync_2ff.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for asynchronous inputs, WIDTH bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture; first stage may go metastable, second resolves it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/confirm_input_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : confirm_input_ctrl
//  Description : Synchronizes and debounces the confirm button, snapshots
//                the switch bank on each accepted press and keeps a
//                read-to-clear confirmation flag plus an overrun flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module confirm_input_ctrl
    import confirm_input_ctrl_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter logic [31:0] CONFIRM_ADDR    = IO_ADDR_CONFIRM
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        buttonRaw,
    input  logic [15:0] switchRaw,
    input  logic        ioRead,
    input  logic [31:0] address,
    output logic        confirmation,
    output logic [15:0] switchLatched,
    output logic        overrun,
    output logic        btnState
);

    localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic        btn_s;
    logic [15:0] sw_s;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             clr;

    logic        conf_q, conf_d;
    logic        ovr_q, ovr_d;
    logic [15:0] latch_q, latch_d;

    sync_2ff #(.WIDTH(1)) u_sync_btn (
        .clk (clk),
        .rst (rst),
        .d_i (buttonRaw),
        .q_o (btn_s)
    );

    sync_2ff #(.WIDTH(16)) u_sync_sw (
        .clk (clk),
        .rst (rst),
        .d_i (switchRaw),
        .q_o (sw_s)
    );

    // FSM state and debounce counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Debounce FSM: a level must hold DEBOUNCE_CYCLES cycles to be accepted
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (btn_s) state_d = ST_DB_PRESS;
            end
            ST_DB_PRESS: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                accept  = 1'b1;
                cnt_d   = '0;
                state_d = ST_HELD;
            end
            ST_HELD: begin
                cnt_d = '0;
                if (!btn_s) state_d = ST_DB_RELEASE;
            end
            ST_DB_RELEASE: begin
                if (btn_s) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign clr = ioRead && (address == CONFIRM_ADDR);

    // Flag update: a new accept wins over a same-cycle clear
    always_comb begin
        conf_d  = conf_q;
        ovr_d   = ovr_q;
        latch_d = latch_q;
        if (clr) begin
            conf_d = 1'b0;
            ovr_d  = 1'b0;
        end
        if (accept) begin
            latch_d = sw_s;
            conf_d  = 1'b1;
            if (conf_q && !clr) ovr_d = 1'b1;
        end
    end

    // Sticky flags and switch snapshot registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conf_q  <= 1'b0;
            ovr_q   <= 1'b0;
            latch_q <= 16'h0000;
        end else begin
            conf_q  <= conf_d;
            ovr_q   <= ovr_d;
            latch_q <= latch_d;
        end
    end

    assign confirmation  = conf_q;
    assign overrun       = ovr_q;
    assign switchLatched = latch_q;
    // Debounced level is high from the accept cycle until release is confirmed
    assign btnState      = (state_q == ST_PRESSED) || (state_q == ST_HELD) ||
                           (state_q == ST_DB_RELEASE);

endmodule : confirm_input_ctrl
`default_nettype wire

// File: tb/tb_confirm_input_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_confirm_input_ctrl
//  Description : Self-checking bench for confirm_input_ctrl (DEBOUNCE=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_confirm_input_ctrl;

    logic        clk;
    logic        rst;
    logic        buttonRaw;
    logic [15:0] switchRaw;
    logic        ioRead;
    logic [31:0] address;
    logic        confirmation;
    logic [15:0] switchLatched;
    logic        overrun;
    logic        btnState;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [15:0] exp_q[$];

    confirm_input_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CONFIRM_ADDR    (32'hFFFF_FF00)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .buttonRaw     (buttonRaw),
        .switchRaw     (switchRaw),
        .ioRead        (ioRead),
        .address       (address),
        .confirmation  (confirmation),
        .switchLatched (switchLatched),
        .overrun       (overrun),
        .btnState      (btnState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Press the button and wait for the accept; clr_at_accept issues the
    // confirm read in the PRESSED cycle so it coincides with the accept.
    task automatic do_press(input logic [15:0] sw, input bit clr_at_accept);
        bit          found;
        logic [15:0] exp;
        switchRaw = sw;
        buttonRaw = 1'b1;
        exp_q.push_back(sw);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (btnState === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total_cnt++;
        if (!found) $display("FAIL press_timeout: btnState=%b want 1 within 30 cycles", btnState);
        else pass_cnt++;
        if (clr_at_accept) begin
            ioRead  = 1'b1;
            address = 32'hFFFF_FF00;
        end
        @(negedge clk);
        ioRead  = 1'b0;
        address = 32'h0;
        exp = exp_q.pop_front();
        total_cnt++;
        if (switchLatched !== exp) $display("FAIL press_latched: got %h want %h", switchLatched, exp);
        else pass_cnt++;
        total_cnt++;
        if (confirmation !== 1'b1) $display("FAIL press_conf: got %b want 1", confirmation);
        else pass_cnt++;
    endtask

    task automatic do_release();
        bit found;
        buttonRaw = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (btnState === 1'b0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total_cnt++;
        if (!found) $display("FAIL release_timeout: btnState=%b want 0 within 30 cycles", btnState);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        buttonRaw = 1'b0;
        switchRaw = 16'h0000;
        ioRead    = 1'b0;
        address   = 32'h0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (confirmation !== 1'b0) $display("FAIL reset_conf: got %b want 0", confirmation);
        else pass_cnt++;
        total_cnt++;
        if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun);
        else pass_cnt++;
        total_cnt++;
        if (switchLatched !== 16'h0000) $display("FAIL reset_latched: got %h want 0000", switchLatched);
        else pass_cnt++;
        total_cnt++;
        if (btnState !== 1'b0) $display("FAIL reset_btn: got %b want 0", btnState);
        else pass_cnt++;
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_glitch();
        switchRaw = 16'hFFFF;
        buttonRaw = 1'b1;
        repeat (3) @(negedge clk);
        buttonRaw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total_cnt++;
            if (btnState !== 1'b0) $display("FAIL glitch_btn[%0d]: got %b want 0", i, btnState);
            else pass_cnt++;
        end
        total_cnt++;
        if (confirmation !== 1'b0) $display("FAIL glitch_conf: got %b want 0", confirmation);
        else pass_cnt++;
        total_cnt++;
        if (switchLatched !== 16'h0000) $display("FAIL glitch_latched: got %h want 0000", switchLatched);
        else pass_cnt++;
    endtask

    task automatic test_basic_press();
        logic [15:0] exp;
        switchRaw = 16'hA5C3;
        buttonRaw = 1'b1;
        exp_q.push_back(16'hA5C3);
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            if (e == 7) begin
                total_cnt++;
                if (confirmation !== 1'b0) $display("FAIL basic_early: conf after edge 7 got %b want 0", confirmation);
                else pass_cnt++;
            end
        end
        exp = exp_q.pop_front();
        total_cnt++;
        if (confirmation !== 1'b1) $display("FAIL basic_conf: after edge 8 got %b want 1", confirmation);
        else pass_cnt++;
        total_cnt++;
        if (switchLatched !== exp) $display("FAIL basic_latched: got %h want %h", switchLatched, exp);
        else pass_cnt++;
        total_cnt++;
        if (btnState !== 1'b1) $display("FAIL basic_btn: got %b want 1", btnState);
        else pass_cnt++;
        total_cnt++;
        if (overrun !== 1'b0) $display("FAIL basic_overrun: got %b want 0", overrun);
        else pass_cnt++;
        switchRaw = 16'h1111;
        repeat (5) @(negedge clk);
        total_cnt++;
        if (switchLatched !== 16'hA5C3) $display("FAIL basic_held_sw: got %h want a5c3", switchLatched);
        else pass_cnt++;
        do_release();
    endtask

    task automatic test_read_clear();
        address = 32'hFFFF_FF00;
        ioRead  = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (confirmation !== 1'b1) $display("FAIL clear_nostrobe: got %b want 1", confirmation);
        else pass_cnt++;
        ioRead  = 1'b1;
        address = 32'hFFFF_FFF1;
        @(negedge clk);
        total_cnt++;
        if (confirmation !== 1'b1) $display("FAIL clear_other_addr: got %b want 1", confirmation);
        else pass_cnt++;
        address = 32'hFFFF_FF00;
        @(negedge clk);
        ioRead  = 1'b0;
        address = 32'h0;
        total_cnt++;
        if (confirmation !== 1'b0) $display("FAIL clear_conf: got %b want 0", confirmation);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        do_press(16'h1234, 1'b0);
        total_cnt++;
        if (overrun !== 1'b0) $display("FAIL overrun_first: got %b want 0", overrun);
        else pass_cnt++;
        do_release();
        do_press(16'h0F0F, 1'b0);
        total_cnt++;
        if (overrun !== 1'b1) $display("FAIL overrun_set: got %b want 1", overrun);
        else pass_cnt++;
        do_release();
        ioRead  = 1'b1;
        address = 32'hFFFF_FF00;
        @(negedge clk);
        ioRead  = 1'b0;
        address = 32'h0;
        total_cnt++;
        if (confirmation !== 1'b0) $display("FAIL overrun_clr_conf: got %b want 0", confirmation);
        else pass_cnt++;
        total_cnt++;
        if (overrun !== 1'b0) $display("FAIL overrun_clr_ovr: got %b want 0", overrun);
        else pass_cnt++;
        total_cnt++;
        if (switchLatched !== 16'h0F0F) $display("FAIL overrun_clr_latched: got %h want 0f0f", switchLatched);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        do_press(16'h5A5A, 1'b0);
        do_release();
        do_press(16'h3C3C, 1'b1);
        total_cnt++;
        if (overrun !== 1'b0) $display("FAIL simul_overrun: got %b want 0", overrun);
        else pass_cnt++;
        do_release();
    endtask

    task automatic test_reset_mid();
        switchRaw = 16'hBEEF;
        buttonRaw = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if ({confirmation, overrun, btnState, switchLatched} !== 19'h0)
            $display("FAIL rstmid_outputs: got conf=%b ovr=%b btn=%b sw=%h want all 0",
                     confirmation, overrun, btnState, switchLatched);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            if (e == 7) begin
                total_cnt++;
                if (confirmation !== 1'b0) $display("FAIL rstmid_early: after edge 7 got %b want 0", confirmation);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (confirmation !== 1'b1) $display("FAIL rstmid_conf: after edge 8 got %b want 1", confirmation);
        else pass_cnt++;
        total_cnt++;
        if (switchLatched !== 16'hBEEF) $display("FAIL rstmid_latched: got %h want beef", switchLatched);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_basic_press();
        test_read_clear();
        test_overrun();
        test_simultaneous();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_confirm_input_ctrl
`default_nettype wire

// File: doc/confirm_input_ctrl.md
Name: confirm_input_ctrl

Overview:
- Front-end controller for the switch IO block.
- Synchronizes and debounces the confirm push-button and samples the 16-bit switch bank.
- Snapshots the switches on each debounced press and raises a sticky `confirmation` flag. The flag is read-to-clear: the CPU polls `0xFFFF_FF00` and, on seeing it set, reads the switch addresses.
- Sits between the board pins and the switch read-mux, so software sees one clean, stable event per physical press.

Parameters:
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive cycles the synchronized button must hold a level to be accepted (press and release). Minimum legal value is 2.
- `CONFIRM_ADDR`, default `32'hFFFF_FF00`: the CPU load address whose read clears `confirmation` and `overrun`.
- `CNT_W`: localparam equal to `$clog2(DEBOUNCE_CYCLES)`. It is not overridable.

Ports:
- `clk`, input, 1: system clock.
- `rst`, input, 1: asynchronous, active-low reset.
- `buttonRaw`, input, 1: raw confirm button, asynchronous to `clk`, active-high.
- `switchRaw`, input, 16: raw switch bank, asynchronous to `clk`.
- `ioRead`, input, 1: CPU IO load strobe, one cycle per load.
- `address`, input, 32: CPU load address, qualified by `ioRead`.
- `confirmation`, output, 1: sticky "new input available" flag, fed to the switch read-mux.
- `switchLatched`, output, 16: switch snapshot taken at the last accepted press.
- `overrun`, output, 1: sticky; a press was accepted while `confirmation` was still set.
- `btnState`, output, 1: debounced button level, for an LED.

Behaviour:
- Reset (`rst`=0, asynchronous): FSM goes to IDLE; counter=0; both synchronizer chains=0. Outputs: `confirmation`=0, `overrun`=0, `switchLatched`=16'h0000, `btnState`=0.
- Synchronization:
  - `buttonRaw` and `switchRaw` each pass through a 2-flop synchronizer, producing `btn_s` and `sw_s`.
  - All logic below uses only the synchronized values.
- FSM states:
  - IDLE: counter=0, `btnState`=0. If `btn_s`=1, go to DB_PRESS.
  - DB_PRESS:
    - If `btn_s`=0, go to IDLE (glitch rejected, no event).
    - Else if counter==`DEBOUNCE_CYCLES`-1, go to PRESSED with counter=0.
    - Else counter++.
  - PRESSED: lasts exactly one cycle. Asserts the internal accept pulse, sets `btnState`=1, then goes to HELD.
  - HELD: `btnState`=1. If `btn_s`=0, go to DB_RELEASE.
  - DB_RELEASE:
    - If `btn_s`=1, go to HELD with counter=0.
    - Else if counter==`DEBOUNCE_CYCLES`-1, go to IDLE.
    - Else counter++.
- Accept pulse, on the edge that ends PRESSED:
  - `switchLatched` <= `sw_s`.
  - `confirmation` <= 1.
  - If `confirmation` was already 1 and no clear occurs this cycle, `overrun` <= 1.
- Latency: with `buttonRaw` held high, `confirmation` is 1 after rising edge `DEBOUNCE_CYCLES`+4, counting from the first edge that samples `buttonRaw`=1.
- Clear: `ioRead`=1 && `address`==`CONFIRM_ADDR` at an edge clears `confirmation` and `overrun` at that edge. The switch read-mux registers at the same edge, so it still captures the pre-clear value 1.
- Simultaneous accept and clear in the same cycle:
  - Set wins: `confirmation`=1.
  - `overrun` is not set.
  - `switchLatched` takes the new value.
- `switchLatched` changes only on accept. Switch motion while the button is held or idle is invisible.
- Reads of any other address have no effect on state.
- Button held forever: exactly one accept. A second accept requires a debounced release, then a debounced press.
- Reset asserted mid-debounce or in HELD aborts immediately. After release of reset the FSM starts in IDLE. If the button is still held, that counts as a new press after a full debounce.
- Counter never exceeds `DEBOUNCE_CYCLES`-1, so there is no wrap-around.

Decomposition:
- Shared IO package holds:
  - IO address constants: `0xFFFF_FF00`, `0xFFFF_FFF1`, `0xFFFF_FFF3`, `0xFFFF_FFF5`, `0xFFFF_FFF7`, `0xFFFF_FFF9`.
  - The 3-bit state encoding: IDLE=0, DB_PRESS=1, PRESSED=2, HELD=3, DB_RELEASE=4.
- Sub-module `sync_2ff`, parameterized by WIDTH, with the same clock and reset. It is instantiated twice (WIDTH=1 and WIDTH=16).

Test Plan (`DEBOUNCE_CYCLES`=4):
- Basic press:
  - Stimulus: `switchRaw`=16'hA5C3, `buttonRaw` 0->1 and held.
  - Required: `confirmation` rises after edge 8; `switchLatched`=16'hA5C3; `btnState`=1; `overrun`=0.
- Glitch rejection:
  - Stimulus: `buttonRaw` high for 3 cycles (synchronized pulse shorter than 4), then low.
  - Required: `confirmation`, `switchLatched` and `btnState` unchanged at 0.
- Read-to-clear:
  - Stimulus: after a press, `ioRead`=1 with `address`=`32'hFFFF_FFF1`, then `address`=`32'hFFFF_FF00`.
  - Required: `confirmation` stays 1 after the first read and is 0 the cycle after the second.
- Overrun:
  - Stimulus: two full press/release cycles (second with `switchRaw`=16'h0F0F), no clear between them.
  - Required: `overrun`=1 and `switchLatched`=16'h0F0F; one read of `32'hFFFF_FF00` clears both flags.
- Simultaneous:
  - Stimulus: the clear read is timed to the PRESSED cycle of a second press.
  - Required: `confirmation`=1, `overrun`=0, `switchLatched` updated.
- Reset mid-operation:
  - Stimulus: `rst`=0 asynchronously during DB_PRESS, button held, `rst` released.
  - Required: all outputs 0 immediately; `confirmation` rises `DEBOUNCE_CYCLES`+4 edges after reset release.
